// File: rtl/corescore_stream_arbiter.sv
// corescore_stream_arbiter
// Round-robin arbiter that lets several AXI-Stream byte sources share one
// character sink. A source owns the sink from its grant until its tlast
// beat, so lines from different emitters never interleave. Every accepted
// byte becomes a one-cycle registered write strobe. A watchdog takes the
// sink back from a source that stalls mid-packet.

module corescore_stream_arbiter #(
  parameter  int NUM_SRC = 4,
  parameter  int TIMEOUT = 1024,
  localparam int GW      = $clog2(NUM_SRC)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [8*NUM_SRC-1:0] i_tdata,
  input  logic [NUM_SRC-1:0]   i_tlast,
  input  logic [NUM_SRC-1:0]   i_tvalid,
  output logic [NUM_SRC-1:0]   o_tready,
  output logic [7:0]           o_dat,
  output logic                 o_val,
  input  logic                 i_ena,
  output logic [GW-1:0]        o_grant,
  output logic                 o_busy,
  output logic                 o_timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Watchdog fires when the idle counter sits at TIMEOUT-1 without a beat.
  localparam logic [15:0] WD_LIMIT   = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;
  localparam logic [GW:0] NUM_SRC_W  = (GW + 1)'(NUM_SRC);

  state_t        state_reg, state_next;
  logic [GW-1:0] last_reg, last_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [7:0]    dat_reg, dat_next;
  logic          val_reg, val_next;
  logic          timeout_reg, timeout_next;
  logic [15:0]   wd_cnt_reg, wd_cnt_next;

  logic [7:0]    src_dat [NUM_SRC];
  logic          rr_hit;
  logic [GW-1:0] rr_pick;
  logic          beat;
  logic          owner_last;
  logic [7:0]    owner_dat;
  logic          wd_expire;

  // Per-source byte lanes and ready: only the owner sees ready, and never
  // in the cycle its previous byte is being strobed into the sink.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_dat[gi]  = i_tdata[8*gi +: 8];
      assign o_tready[gi] = (state_reg == LOCK) && (grant_reg == GW'(gi))
                            && i_ena && !val_reg;
    end
  endgenerate

  assign beat       = |(i_tvalid & o_tready);
  assign owner_last = i_tlast[grant_reg];
  assign owner_dat  = src_dat[grant_reg];
  assign wd_expire  = (TIMEOUT > 0) && (wd_cnt_reg == WD_LIMIT);

  // Round-robin search starting just after the previous owner; scanning
  // offsets from farthest to nearest lets the nearest requester win.
  always_comb begin
    logic [GW:0] idx_wide;
    rr_hit   = 1'b0;
    rr_pick  = last_reg;
    idx_wide = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx_wide = {1'b0, last_reg} + (GW + 1)'(k);
      if (idx_wide >= NUM_SRC_W) begin
        idx_wide = idx_wide - NUM_SRC_W;
      end
      if (i_tvalid[idx_wide[GW-1:0]]) begin
        rr_hit  = 1'b1;
        rr_pick = idx_wide[GW-1:0];
      end
    end
  end

  // Next-state, ownership, sink strobe and watchdog decisions.
  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    grant_next   = grant_reg;
    dat_next     = dat_reg;
    val_next     = 1'b0;
    timeout_next = 1'b0;
    wd_cnt_next  = wd_cnt_reg;
    case (state_reg)
      IDLE: begin
        wd_cnt_next = 16'd0;
        if (rr_hit) begin
          state_next = LOCK;
          grant_next = rr_pick;
        end
      end
      LOCK: begin
        if (beat) begin
          // A beat always wins over an expiring watchdog.
          val_next    = 1'b1;
          dat_next    = owner_dat;
          wd_cnt_next = 16'd0;
          if (owner_last) begin
            state_next = IDLE;
            last_next  = grant_reg;
          end
        end else if (wd_expire) begin
          state_next   = IDLE;
          last_next    = grant_reg;
          timeout_next = 1'b1;
          wd_cnt_next  = 16'd0;
        end else if (TIMEOUT > 0) begin
          wd_cnt_next = wd_cnt_reg + 16'd1;
        end else begin
          wd_cnt_next = 16'd0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      last_reg    <= GW'(NUM_SRC - 1);
      grant_reg   <= '0;
      dat_reg     <= 8'd0;
      val_reg     <= 1'b0;
      timeout_reg <= 1'b0;
      wd_cnt_reg  <= 16'd0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      grant_reg   <= grant_next;
      dat_reg     <= dat_next;
      val_reg     <= val_next;
      timeout_reg <= timeout_next;
      wd_cnt_reg  <= wd_cnt_next;
    end
  end

  assign o_dat     = dat_reg;
  assign o_val     = val_reg;
  assign o_grant   = grant_reg;
  assign o_busy    = (state_reg == LOCK);
  assign o_timeout = timeout_reg;

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Directed bench for corescore_stream_arbiter: four sources, watchdog of
// eight idle cycles. Source byte queues live in the bench; every sink strobe
// is logged as {grant, byte} and compared against hand-computed sequences.

module tb_corescore_stream_arbiter;

  localparam int NS = 4;
  localparam int GWB = 2;

  logic            clk = 1'b0;
  logic            i_rst;
  logic [8*NS-1:0] i_tdata;
  logic [NS-1:0]   i_tlast;
  logic [NS-1:0]   i_tvalid;
  logic [NS-1:0]   o_tready;
  logic [7:0]      o_dat;
  logic            o_val;
  logic            i_ena;
  logic [GWB-1:0]  o_grant;
  logic            o_busy;
  logic            o_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] src_mem [NS][32];
  int         src_rd [NS];
  int         src_wr [NS];
  logic [9:0] cap [32];
  logic [9:0] exp_cap [32];
  int         cap_n;

  corescore_stream_arbiter #(.NUM_SRC(NS), .TIMEOUT(8)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .o_tready (o_tready),
    .o_dat    (o_dat),
    .o_val    (o_val),
    .i_ena    (i_ena),
    .o_grant  (o_grant),
    .o_busy   (o_busy),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] enc(int g, logic [7:0] d);
    logic [1:0] gs;
    gs = g[1:0];
    return {gs, d};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(int k, logic [7:0] d, logic l);
    src_mem[k][src_wr[k]] = {l, d};
    src_wr[k]++;
  endtask

  task automatic clear_srcs();
    for (int k = 0; k < NS; k++) begin
      src_rd[k] = 0;
      src_wr[k] = 0;
    end
  endtask

  task automatic clear_cap();
    cap_n = 0;
    for (int i = 0; i < 32; i++) cap[i] = '0;
  endtask

  // Present the head of each source queue on the stream inputs.
  task automatic drive();
    for (int k = 0; k < NS; k++) begin
      if (src_rd[k] < src_wr[k]) begin
        i_tvalid[k]       = 1'b1;
        i_tdata[8*k +: 8] = src_mem[k][src_rd[k]][7:0];
        i_tlast[k]        = src_mem[k][src_rd[k]][8];
      end else begin
        i_tvalid[k]       = 1'b0;
        i_tdata[8*k +: 8] = 8'h00;
        i_tlast[k]        = 1'b0;
      end
    end
    #1;
  endtask

  // One clock: note handshakes before the edge, then advance queues,
  // re-drive the sources and log any sink strobe.
  task automatic tick();
    logic [NS-1:0] beat;
    beat = i_tvalid & o_tready;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NS; k++) begin
      if (beat[k]) src_rd[k]++;
    end
    drive();
    if (o_val && cap_n < 32) begin
      cap[cap_n] = {o_grant, o_dat};
      $display("cycle %0d: strobe src=%0d byte=%02h", cyc, o_grant, o_dat);
      cap_n++;
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_caps(string tag, int n);
    check($sformatf("%s_count", tag), 32'(cap_n), 32'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(exp_cap[i]));
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    clear_srcs();
    drive();
    ticks(2);
    i_rst = 1'b0;
    clear_cap();
  endtask

  initial begin
    i_rst    = 1'b1;
    i_ena    = 1'b1;
    i_tdata  = '0;
    i_tlast  = '0;
    i_tvalid = '0;
    clear_srcs();
    clear_cap();

    // Reset state
    do_reset();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_val", 32'(o_val), 32'd0);
    check("rst_dat", 32'(o_dat), 32'd0);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    check("rst_tready", 32'(o_tready), 32'd0);

    // Single-source packet on source 2
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
    drive();
    tick();
    check("t1_busy", 32'(o_busy), 32'd1);
    check("t1_grant", 32'(o_grant), 32'd2);
    check("t1_tready", 32'(o_tready), 32'h4);
    ticks(5);
    check("t1_last_val", 32'(o_val), 32'd1);
    check("t1_last_dat", 32'(o_dat), 32'h43);
    check("t1_busy_fall", 32'(o_busy), 32'd0);
    ticks(2);
    exp_cap[0] = enc(2, 8'h41); exp_cap[1] = enc(2, 8'h42); exp_cap[2] = enc(2, 8'h43);
    check_caps("t1", 3);

    // Contention: sources 0, 1, 3 request together from reset
    do_reset();
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
    push(0, 8'h05, 1'b0); push(0, 8'h06, 1'b1);
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
    push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b1);
    drive();
    tick();
    check("t2_first_grant", 32'(o_grant), 32'd0);
    ticks(19);
    exp_cap[0] = enc(0, 8'h01); exp_cap[1] = enc(0, 8'h02);
    exp_cap[2] = enc(1, 8'h11); exp_cap[3] = enc(1, 8'h12);
    exp_cap[4] = enc(3, 8'h31); exp_cap[5] = enc(3, 8'h32);
    exp_cap[6] = enc(0, 8'h05); exp_cap[7] = enc(0, 8'h06);
    check_caps("t2", 8);

    // Sink backpressure: i_ena low for 5 cycles mid-packet
    clear_cap();
    push(2, 8'h51, 1'b0); push(2, 8'h52, 1'b0); push(2, 8'h53, 1'b1);
    drive();
    tick();
    check("t3_grant", 32'(o_grant), 32'd2);
    check("t3_tready", 32'(o_tready), 32'h4);
    tick();
    i_ena = 1'b0;
    #1;
    check("t3_stall_tready0", 32'(o_tready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3_stall_tready%0d", i + 1), 32'(o_tready), 32'd0);
      check($sformatf("t3_stall_val%0d", i + 1), 32'(o_val), 32'd0);
    end
    i_ena = 1'b1;
    #1;
    check("t3_resume_tready", 32'(o_tready), 32'h4);
    ticks(6);
    exp_cap[0] = enc(2, 8'h51); exp_cap[1] = enc(2, 8'h52); exp_cap[2] = enc(2, 8'h53);
    check_caps("t3", 3);

    // Watchdog: source 1 stalls after one byte, source 2 waits
    clear_cap();
    push(1, 8'h61, 1'b0);
    push(2, 8'h71, 1'b1);
    drive();
    tick();
    check("t4_grant1", 32'(o_grant), 32'd1);
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("t4_hold_busy%0d", i), 32'(o_busy), 32'd1);
      check($sformatf("t4_hold_to%0d", i), 32'(o_timeout), 32'd0);
    end
    tick();
    check("t4_timeout_pulse", 32'(o_timeout), 32'd1);
    check("t4_timeout_idle", 32'(o_busy), 32'd0);
    check("t4_timeout_grant", 32'(o_grant), 32'd1);
    tick();
    check("t4_pulse_end", 32'(o_timeout), 32'd0);
    check("t4_grant2", 32'(o_grant), 32'd2);
    check("t4_busy2", 32'(o_busy), 32'd1);
    ticks(2);
    exp_cap[0] = enc(1, 8'h61); exp_cap[1] = enc(2, 8'h71);
    check_caps("t4", 2);

    // Reset during source 0's second byte
    clear_cap();
    push(0, 8'h81, 1'b0); push(0, 8'h82, 1'b0); push(0, 8'h83, 1'b1);
    drive();
    ticks(3);
    check("t5_pre_dat", 32'(o_dat), 32'h81);
    check("t5_pre_tready", 32'(o_tready), 32'h1);
    i_rst = 1'b1;
    tick();
    check("t5_rst_busy", 32'(o_busy), 32'd0);
    check("t5_rst_val", 32'(o_val), 32'd0);
    check("t5_rst_dat", 32'(o_dat), 32'd0);
    check("t5_rst_grant", 32'(o_grant), 32'd0);
    check("t5_rst_tready", 32'(o_tready), 32'd0);
    i_rst = 1'b0;
    clear_srcs();
    clear_cap();
    push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
    push(3, 8'hB1, 1'b1);
    drive();
    tick();
    check("t5_regrant0", 32'(o_grant), 32'd0);
    check("t5_regrant_busy", 32'(o_busy), 32'd1);
    ticks(8);
    exp_cap[0] = enc(0, 8'hA1); exp_cap[1] = enc(0, 8'hA2);
    exp_cap[2] = enc(0, 8'hA3); exp_cap[3] = enc(3, 8'hB1);
    check_caps("t5", 4);

    // Back-to-back single-byte packets on sources 0 and 1
    clear_cap();
    for (int i = 0; i < 3; i++) begin
      push(0, 8'hC0 + 8'(i), 1'b1);
      push(1, 8'hD0 + 8'(i), 1'b1);
    end
    drive();
    ticks(14);
    for (int i = 0; i < 3; i++) begin
      exp_cap[2*i]     = enc(0, 8'hC0 + 8'(i));
      exp_cap[2*i + 1] = enc(1, 8'hD0 + 8'(i));
    end
    check_caps("t6", 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/corescore_stream_arbiter.md
# corescore_stream_arbiter

Packet-aware round-robin arbiter that shares one byte-wide character sink (UART or JTAG-UART) between NUM_SRC independent AXI-Stream byte sources, such as per-core or per-cluster emitters. It owns a source until that source's `tlast` beat, so message lines never interleave. It registers each accepted byte into a one-cycle write strobe for the sink. A watchdog releases a source that stalls mid-packet.

## Interface
- `NUM_SRC`, default 4: number of sources, legal range 2..16.
- `TIMEOUT`, default 1024: idle cycles allowed mid-packet before forced release. 0 disables the watchdog.
- `GW`, derived: `$clog2(NUM_SRC)`.

Ports:
- `i_clk` in 1: single clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_tdata` in 8*NUM_SRC: source k byte at bits [8k+7:8k].
- `i_tlast` in NUM_SRC: per-source last-byte-of-packet flag.
- `i_tvalid` in NUM_SRC: per-source byte valid.
- `o_tready` out NUM_SRC: per-source ready, combinational.
- `o_dat` out 8: byte to sink, registered.
- `o_val` out 1: sink write strobe, registered, one cycle per byte.
- `i_ena` in 1: sink can accept a byte.
- `o_grant` out GW: index of current/last owner.
- `o_busy` out 1: high while a source owns the sink.
- `o_timeout` out 1: one-cycle pulse on forced release.

## Operation
- FSM with two states, IDLE and LOCK. A `last` pointer (GW bits) records the previous owner.
- **IDLE:** search `i_tvalid` round-robin starting at `last+1` (mod NUM_SRC), then wrapping.
  - First hit g: next cycle state=LOCK, `o_grant`=g, `o_busy`=1.
  - No hit: remain in IDLE.
- **LOCK:**
  - `o_tready[g] = i_ena & ~o_val`. All other `o_tready` bits are 0. In IDLE all `o_tready`=0.
  - Beat = `i_tvalid[g] & o_tready[g]`.
  - On a beat, next cycle: `o_dat`=`i_tdata[g]` and `o_val`=1. Otherwise `o_val`=0. This enforces at most one byte per 2 cycles and gives the sink its required one-cycle gap after `i_ena`.
  - Beat with `i_tlast[g]`=1: next state IDLE, `last`<=g, `o_busy`<=0.
  - `i_tvalid[g]` low mid-packet: stay in LOCK. Bytes from other sources are not accepted.
- **Watchdog (TIMEOUT>0):**
  - 16-bit counter, cleared on entry to LOCK and on every beat. Increments each LOCK cycle without a beat.
  - Reaching TIMEOUT-1 with no beat that cycle forces IDLE, sets `last`<=g, and pulses `o_timeout` for 1 cycle.
  - A beat in the same cycle as the limit wins: counter clears, no timeout.
- `o_grant` holds its last owner while in IDLE.
- `o_dat` holds its value when `o_val`=0.

## Timing
- Reset values:
  - State IDLE.
  - `last`=NUM_SRC-1, so source 0 has first priority.
  - `o_grant`=0, `o_busy`=0, `o_val`=0, `o_dat`=0, `o_timeout`=0, counter=0.
  - `o_tready` all 0.
- Reset mid-packet: the partial packet is abandoned and no further strobe is issued. The first post-reset cycle behaves as IDLE.
- Latencies:
  - `i_tvalid` rise in IDLE to `o_tready` high: 1 cycle, if `i_ena`=1.
  - Beat to `o_val`: 1 cycle.
  - `tlast` beat to next grant: IDLE is entered 1 cycle after the beat. The next grant is visible 1 cycle later, so there are 2 cycles from the `tlast` beat to the next owner's `o_tready`.
- `i_ena` low: no beats and `o_tready`=0. The watchdog keeps counting, because a sink stall is indistinguishable from a source stall.
- Simultaneous requests in IDLE: the lowest index at or after `last+1` (circular) wins.
- Single-byte packet (`tvalid` and `tlast` on the same beat): LOCK lasts until that beat, then back to IDLE.

## Test plan
- **Single-source packet:** source 2 sends 0x41, 0x42, 0x43 (tlast on 0x43), `i_ena`=1 → `o_val` pulses carry 0x41, 0x42, 0x43 on alternate cycles; `o_grant`=2; `o_busy` falls 1 cycle after the 0x43 beat.
- **Contention and fairness:** sources 0, 1 and 3 all hold 2-byte packets from reset → packet order 0, 1, 3, then 0 again if it re-requests; no byte interleaving between packets.
- **Sink backpressure:** hold `i_ena`=0 for 5 cycles mid-packet → `o_tready`=0 and no `o_val` during the stall; data resumes intact and in order with no duplicates.
- **Watchdog:** TIMEOUT=8; source 1 sends 1 byte without tlast, then drops `tvalid` → after 8 idle cycles in LOCK, `o_timeout` pulses, state goes IDLE, and a pending source 2 is granted next.
- **Reset mid-packet:** assert `i_rst` for 1 cycle during source 0's second byte → all outputs at reset values the next cycle; afterwards source 0 restarts and wins over source 3 because `last`=NUM_SRC-1.
- **Back-to-back single-byte packets:** sources 0 and 1 each send continuous single-byte packets → grant alternates 0, 1, 0, 1; each packet has exactly one `o_val`.
